// File: rtl/core_pkg.sv
// Shared opcode constants and state/class enums for the core sequencer.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Latency counter width; covers MEM_LATENCY up to 8 (counts 0..7).
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JUMP,
        C_SYSTEM,
        C_ILLEGAL
    } inst_class_t;

endpackage

// File: rtl/inst_class_decode.sv
// Combinational instruction classifier: opcode to class, plus whether rd is written.
module inst_class_decode
    import core_pkg::*;
(
    input  logic [11:0]  ir,
    output inst_class_t  cls,
    output logic         writes_rd
);

    always_comb begin
        cls = C_ILLEGAL;
        case (ir[6:0])
            OP_R, OP_I, OP_LUI, OP_AUIPC: cls = C_ALU;
            OP_LOAD:                      cls = C_LOAD;
            OP_STORE:                     cls = C_STORE;
            OP_BRANCH:                    cls = C_BRANCH;
            OP_JAL, OP_JALR:              cls = C_JUMP;
            OP_SYSTEM:                    cls = C_SYSTEM;
            default:                      cls = C_ILLEGAL;
        endcase
    end

    // x0 is hardwired, so a write to it is suppressed here rather than in the regfile.
    assign writes_rd = ((cls == C_ALU) || (cls == C_LOAD) || (cls == C_JUMP)) &&
                       (ir[11:7] != 5'd0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer owning PC, IR,
// write strobes, halt/fault status and the retired-instruction counter.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        stall,
    input  logic [31:0] inst,
    input  logic        branch_taken,
    input  logic [31:0] jump_target,
    output logic [31:0] inst_addr,
    output logic [31:0] ir,
    output logic        rf_we,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted,
    output logic        fault
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

    seq_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      pc, npc, npc_calc;
    inst_class_t      cls;
    logic             writes_rd;
    logic             ir_ld, npc_ld, halt_set, fault_set;
    logic             wb_raw, rd_raw, wr_raw, active;

    inst_class_decode u_dec (
        .ir        (ir[11:0]),
        .cls       (cls),
        .writes_rd (writes_rd)
    );

    // Strobes vanish immediately on stall or reset assertion, not at the next edge.
    assign active = !stall && !rst_b;

    assign npc_calc = ((cls == C_JUMP) || ((cls == C_BRANCH) && branch_taken)) ?
                      jump_target : pc + 32'd4;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ir_ld     = 1'b0;
        npc_ld    = 1'b0;
        halt_set  = 1'b0;
        fault_set = 1'b0;
        wb_raw    = 1'b0;
        rd_raw    = 1'b0;
        wr_raw    = 1'b0;
        case (state)
            S_FETCH: begin
                if (cnt == LAST) begin
                    ir_ld    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_DECODE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_SYSTEM: begin
                        halt_set = 1'b1;
                        state_nx = S_HALT;
                    end
                    C_ILLEGAL: begin
                        halt_set  = 1'b1;
                        fault_set = 1'b1;
                        state_nx  = S_HALT;
                    end
                    default: state_nx = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                // A misaligned target faults before PC moves, so PC keeps the culprit's address.
                if (npc_calc[1:0] != 2'b00) begin
                    halt_set  = 1'b1;
                    fault_set = 1'b1;
                    state_nx  = S_HALT;
                end else begin
                    npc_ld   = 1'b1;
                    state_nx = ((cls == C_LOAD) || (cls == C_STORE)) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (cls == C_STORE) begin
                    wr_raw   = 1'b1;
                    state_nx = S_WB;
                end else begin
                    rd_raw = 1'b1;
                    if (cnt == LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_WB;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_WB: begin
                wb_raw   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= S_FETCH;
        end else if (!stall) begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            cnt     <= '0;
            pc      <= RESET_PC;
            npc     <= RESET_PC;
            ir      <= '0;
            instret <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else if (!stall) begin
            cnt <= cnt_nx;
            if (ir_ld)     ir      <= inst;
            if (npc_ld)    npc     <= npc_calc;
            if (halt_set)  halted  <= 1'b1;
            if (fault_set) fault   <= 1'b1;
            if (wb_raw) begin
                pc      <= npc;
                instret <= instret + 32'd1;
            end
        end
    end

    assign inst_addr    = pc;
    assign retire       = wb_raw & active;
    assign rf_we        = wb_raw & writes_rd & active;
    assign mem_read_en  = rd_raw & active;
    assign mem_write_en = wr_raw & active;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the `riscv_core` datapath (`regfile`, `control`, `ALU`) through fetch, decode, execute, memory and writeback. It replaces the free-running `inst_addr + 4` update. It owns the PC, instruction register, write-enable pulses, halt/fault status and a retired-instruction counter. It tolerates multi-cycle instruction and data memory latency.

## Interface
Reset: one clock; reset is asynchronous and active-high.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `MEM_LATENCY`, default 1: cycles from address/enable to valid data, for both `inst` and `mem_data_out`. Legal range 1..8.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  asynchronous reset, active-high despite the `_b` name
- `stall`  in  1  external hold; freezes state, counters and all pulses
- `inst`  in  32  instruction memory read data
- `branch_taken`  in  1  branch condition from the datapath, sampled in EXECUTE
- `jump_target`  in  32  branch/jump target from the datapath, sampled in EXECUTE
- `inst_addr`  out  32  current PC
- `ir`  out  32  latched instruction register
- `rf_we`  out  1  regfile write-enable pulse
- `mem_read_en`  out  1  data memory read strobe
- `mem_write_en`  out  1  data memory write strobe
- `retire`  out  1  one-cycle pulse per retired instruction
- `instret`  out  32  retired-instruction count
- `halted`  out  1  sticky; set on `ecall` or fault
- `fault`  out  1  sticky; illegal opcode or misaligned target

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- **FETCH**
  - Drive `inst_addr` = PC.
  - Count `MEM_LATENCY` cycles, latch `inst` into `ir`, then go to DECODE.
- **DECODE** classifies `ir[6:0]`:
  - 0x33, 0x13, 0x37, 0x17: ALU class.
  - 0x03: load. 0x23: store. 0x63: branch. 0x6F, 0x67: jump.
  - 0x73: go to HALT with `halted`=1, `fault`=0.
  - Any other opcode: go to HALT with `halted`=1, `fault`=1.
  - Every non-halting class goes to EXECUTE.
- **EXECUTE** (1 cycle): compute next PC.
  - Branch: `jump_target` if `branch_taken`=1, else PC+4.
  - Jump: always `jump_target`.
  - All other classes: PC+4.
  - If the next PC has bits [1:0] ≠ 0: go to HALT with `fault`=1. PC is unchanged and nothing retires.
  - Load/store go to MEM; all others go to WB.
- **MEM**
  - Store: `mem_write_en`=1 for exactly one cycle, then WB.
  - Load: `mem_read_en`=1 for `MEM_LATENCY` cycles, then WB.
- **WB** (1 cycle)
  - PC ← next PC; `retire`=1; `instret` += 1 (wraps at 2^32).
  - `rf_we`=1 for ALU, load and jump classes, only when `ir[11:7]` ≠ 0.
  - Then FETCH.
- **HALT**: absorbing until reset. PC holds the address of the halting instruction. All strobes stay 0.
- **`stall`** (any state): hold state, PC, `ir`, latency counter and `instret`. Force `rf_we`, `mem_read_en`, `mem_write_en` and `retire` to 0. A store's write pulse is deferred, never duplicated.
- Strobes are combinational from state, gated by `!stall`. All other outputs are registered.

## Timing
- Reset values:
  - State = FETCH, PC = `RESET_PC`, `ir`=0, `instret`=0.
  - `halted`=0, `fault`=0, all strobes 0.
  - Strobes drop in the same cycle reset asserts.
- Reset mid-instruction aborts it: no write, no retire.
- Cycles per instruction, with L = `MEM_LATENCY` and no stall:
  - ALU, branch, jump: L+3.
  - Store: L+4.
  - Load: 2L+3.
- Halt latency: `halted` rises L+1 cycles after FETCH entry for `ecall`.
- `ir` updates on the last FETCH cycle. PC updates at the end of WB.

## Structure
- Shared package `core_pkg`:
  - Opcode localparams (`OP_R`=0x33, `OP_I`=0x13, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`, `OP_SYSTEM`=0x73).
  - `seq_state_t` enum.
  - `inst_class_t` enum.
- Sub-module `inst_class_decode`: combinational, maps `ir` to `inst_class_t` plus `writes_rd`.

## Test plan
- Reset with `RESET_PC`=0x100, L=1; feed `addi` x1 → `inst_addr`=0x100; `rf_we` pulses in cycle 4; `inst_addr`=0x104; `instret`=1.
- `sw` then `lw`, L=3 → `mem_write_en` high exactly 1 cycle; `mem_read_en` high 3 cycles; `lw` retires 9 cycles after FETCH entry.
- `beq` with `branch_taken`=1, `jump_target`=0x40 → PC=0x40; `rf_we` never asserted. Then target 0x42 → `fault`=1, `halted`=1, PC held.
- `ecall` at 0x8 → `halted`=1, `fault`=0, `instret` unchanged. Opcode 0x7F → `fault`=1.
- `stall` held 5 cycles during store MEM → exactly one `mem_write_en` cycle after release. `rst_b` pulse mid-load → no `rf_we`, PC=`RESET_PC`.
- Preload `instret`=0xFFFF_FFFF via a long run (or force), retire once → `instret`=0. `addi` x0 → no `rf_we`.
